// File: rtl/num_conv_pkg.sv
// num_conv_pkg: shared widths, reset char word and FSM state encoding for num_conv_sched.
package num_conv_pkg;
    localparam int NUM_W = 10;
    localparam int CHAR_W = 32;
    localparam logic [CHAR_W-1:0] CHAR_RESET = 32'h30303030;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_t;
endpackage

// File: rtl/num_conv_sched_rr_arb.sv
// rr_arb: N-way round-robin arbiter, first requester at or above ptr (with wrap) wins.
module rr_arb #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);
    logic [W-1:0] j;
    // Scan offsets from high to low so the smallest offset from ptr is the last to win.
    always_comb begin
        idx = '0;
        any = 1'b0;
        j = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = W'((int'(ptr) + k) % N);
            if (req[j]) begin
                idx = j;
                any = 1'b1;
            end
        end
        gnt = any ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/num_conv_sched.sv
// num_conv_sched: round-robin sharing of one registered number-to-ASCII converter among N_REQ requesters.
// Optional per-requester result cache enabled by defining NUM_CONV_SCHED_CACHE_EN.
module num_conv_sched
    import num_conv_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CONV_LAT = 2,
    parameter int ID_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [NUM_W*N_REQ-1:0] req_num,
    output logic [N_REQ-1:0]       req_ready,
    output logic [NUM_W-1:0]       conv_num,
    input  logic [CHAR_W-1:0]      conv_char,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [CHAR_W-1:0]      rsp_char,
    output logic                   busy
);
    localparam int CW = $clog2(CONV_LAT + 1);

    state_t            state, nxt;
    logic [ID_W-1:0]   ptr, idx;
    logic [N_REQ-1:0]  gnt;
    logic              any, accept, cap, hit;
    logic [CW-1:0]     cnt;
    logic [NUM_W-1:0]  sel_num;
    logic [CHAR_W-1:0] cap_char;

    rr_arb #(.N(N_REQ), .W(ID_W)) u_arb (
        .req(req_valid),
        .ptr(ptr),
        .gnt(gnt),
        .idx(idx),
        .any(any)
    );

    assign sel_num = req_num[NUM_W*idx +: NUM_W];
    assign accept = state == ST_IDLE && any;
    assign cap = state == ST_WAIT && cnt == CW'(CONV_LAT);
    assign req_ready = (state == ST_IDLE && rst_n) ? gnt : '0;
    assign busy = state != ST_IDLE;

`ifdef NUM_CONV_SCHED_CACHE_EN
    logic [N_REQ-1:0]  c_vld;
    logic [NUM_W-1:0]  c_num [N_REQ];
    logic [CHAR_W-1:0] c_char [N_REQ];
    logic              hit_r;
    assign hit = c_vld[idx] && c_num[idx] == sel_num;
    assign cap_char = hit_r ? c_char[rsp_id] : conv_char;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_vld <= '0;
            hit_r <= 1'b0;
        end else begin
            if (accept) hit_r <= hit;
            if (cap && !hit_r) c_vld[rsp_id] <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (cap && !hit_r) begin
            c_num[rsp_id] <= conv_num;
            c_char[rsp_id] <= conv_char;
        end
    end
`else
    assign hit = 1'b0;
    assign cap_char = conv_char;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        nxt = state == ST_IDLE ? (any ? ST_WAIT : ST_IDLE) :
              state == ST_WAIT ? (cap ? ST_RESP : ST_WAIT) :
              state == ST_RESP ? (rsp_ready ? ST_IDLE : ST_RESP) : ST_IDLE;
    end

    // A cache hit preloads the counter so capture of the cached word lands on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            conv_num <= '0;
            rsp_valid <= 1'b0;
            rsp_id <= '0;
            rsp_char <= CHAR_RESET;
            cnt <= '0;
        end else begin
            if (accept) begin
                rsp_id <= idx;
                ptr <= idx == ID_W'(N_REQ - 1) ? '0 : idx + 1'b1;
                cnt <= hit ? CW'(CONV_LAT) : '0;
                if (!hit) conv_num <= sel_num;
            end
            if (state == ST_WAIT && !cap) cnt <= cnt + 1'b1;
            if (cap) begin
                rsp_char <= cap_char;
                rsp_valid <= 1'b1;
            end
            if (state == ST_RESP && rsp_ready) rsp_valid <= 1'b0;
        end
    end
endmodule

// File: doc/num_conv_sched.md
Name: num_conv_sched

Overview:
- Round-robin scheduler that shares one registered number-to-ASCII converter (10-bit in, 32-bit char out, fixed pipeline latency) among N_REQ requesters.
- Per transaction: accepts one request, drives the converter, waits out its latency, captures the 32-bit char word, then returns it tagged with the requester id.
- Sits in the seg display path between value sources (counters, sensors) and the display-string logic.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CONV_LAT, 2, converter latency in clk edges from a stable num input to a valid char output.
- ID_W, $clog2(N_REQ), width of the requester id.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  per-requester request strobe; held until accepted.
- req_num  input  10*N_REQ  packed values; requester i uses bits [10*i+9:10*i].
- req_ready  output  N_REQ  one-hot accept, combinational.
- conv_num  output  10  registered num input to the shared converter.
- conv_char  input  32  char output of the shared converter.
- rsp_valid  output  1  response valid, registered.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_W  index of the requester being answered.
- rsp_char  output  32  captured ASCII word.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset values (asynchronous, on rst_n low): state IDLE, rr pointer 0, conv_num 0, rsp_valid 0, rsp_id 0, rsp_char 32'h30303030 ("0000"), busy 0, wait counter 0. Reset mid-transaction abandons it with no response.
- IDLE:
  - Grant goes to the first i with req_valid[i]=1, scanning from the pointer upward with wrap.
  - req_ready[i]=1 combinationally for the granted i only; all other bits 0; all bits 0 outside IDLE.
  - On the accepting edge E0: conv_num <= req_num slice i, rsp_id <= i, pointer <= (i+1) mod N_REQ, cnt <= 0, go to WAIT.
  - No req_valid set: stay in IDLE, pointer unchanged.
- WAIT:
  - conv_num is held constant; cnt increments each edge.
  - At the edge where cnt==CONV_LAT: rsp_char <= conv_char, rsp_valid <= 1, go to RESP. Capture therefore happens at E0+CONV_LAT+1.
- RESP:
  - rsp_valid, rsp_id and rsp_char are held stable until rsp_ready=1.
  - On the edge with rsp_valid & rsp_ready: rsp_valid <= 0, go to IDLE.
  - A new grant is possible at the very next edge, so minimum spacing is CONV_LAT+3 cycles per transaction.
- Latency: accept edge to rsp_valid high = CONV_LAT+1 cycles.
- Requests arriving during WAIT or RESP wait in place; requesters must hold req_valid and req_num stable until req_ready.
- Dropping req_valid before acceptance is legal; that requester is simply skipped.
- Simultaneous requests: strict round-robin from the pointer; no starvation, worst-case wait N_REQ-1 transactions.
- Pointer wrap: i = N_REQ-1 sets pointer to 0.
- Out-of-range num (>999) is passed through unchanged; the converter's result is returned as-is.

Optional Feature:
- Macro: NUM_CONV_SCHED_CACHE_EN.
- When defined:
  - Per-requester cache entry: valid bit, last num, last char. All valid bits clear on reset.
  - On grant, if the entry is valid and its num equals req_num, skip WAIT: rsp_char <= cached char, rsp_valid <= 1 at E0+1, conv_num unchanged.
  - On a miss, normal conversion; at capture the entry is written (valid, num, char).
- When undefined: no cache storage; every request converts.

Decomposition:
- Shared package num_conv_pkg: state encoding constants (ST_IDLE, ST_WAIT, ST_RESP), CHAR_RESET = 32'h30303030, NUM_W = 10, CHAR_W = 32.
- One natural sub-module: rr_arb (N-way round-robin arbiter: req vector, pointer input, one-hot grant plus encoded index).
- The FSM and datapath stay in num_conv_sched.

Test Plan:
- Reset: rst_n low with requests pending -> rsp_valid=0, rsp_char=32'h30303030, busy=0, req_ready=0.
- Single request: req_valid[2]=1, num=407, converter model outputs "-407", rsp_ready=1 -> req_ready[2] pulses once; rsp_valid 3 cycles later with rsp_id=2, rsp_char="-407".
- All four requesting from pointer 0, nums 1/22/333/999 -> responses in id order 0,1,2,3 with chars "-001", "-022", "-333", "-999"; pointer ends at 0.
- Backpressure: rsp_ready held 0 for 5 cycles -> rsp_char and rsp_id stable, busy=1, no req_ready; accept completes on the first rsp_ready=1 cycle.
- Mid-transaction reset: rst_n pulsed low during WAIT -> no response; next request served from pointer 0.
- NUM_CONV_SCHED_CACHE_EN defined: requester 1 sends 55 twice -> first response at latency 3, second at latency 1 with rsp_char "-055" and conv_num unchanged.
